// File: rtl/wr_req_arbiter_pkg.sv
// rtl/wr_req_arbiter_pkg.sv - shared constants and mdata tag helpers for wr_req_arbiter
//
// Default parameter values, width helpers and the client-ID tag/untag
// functions. The client ID occupies the top CID_W bits of the CCI mdata,
// i.e. mdata[MDATA-1 -: CID_W]; the low MDATA-CID_W bits belong to the client.
// The helpers work on 64-bit containers so any legal parameter set fits;
// callers cast the result back to their own width.
package wr_req_arbiter_pkg;

    localparam int ADDR_LMT_DEF    = 20;
    localparam int MDATA_DEF       = 14;
    localparam int CACHE_WIDTH_DEF = 512;
    localparam int CLIENTS_DEF     = 2;
    localparam int CID_W_DEF       = 1;
    localparam int MAX_OUT_DEF     = 32;

    // LSB position of the client-ID field inside the CCI mdata.
    function automatic int cid_lsb(input int mdata_w, input int cid_w);
        return mdata_w - cid_w;
    endfunction

    // Outstanding counter width: must hold 0..MAX_OUT inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Width of a client index (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // {cid, low}: place the client ID above the low_w client mdata bits.
    function automatic logic [63:0] tag_mdata(input logic [63:0] cid,
                                              input logic [63:0] low,
                                              input int          low_w);
        return (cid << low_w) | low;
    endfunction

    // Extract the client-ID field from a CCI mdata value.
    function automatic logic [63:0] mdata_cid(input logic [63:0] mdata,
                                              input int          low_w,
                                              input int          cid_w);
        return (mdata >> low_w) & ((64'd1 << cid_w) - 64'd1);
    endfunction

endpackage

// File: rtl/wr_req_arbiter_rr_arbiter.sv
// rtl/wr_req_arbiter_rr_arbiter.sv - round-robin request/grant arbiter
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-requester eligible request
//   block     : suppresses all grants this cycle
//   gnt       : combinational one-hot grant
//   gnt_idx   : index of the granted requester (valid when |gnt)
// The last-grant pointer resets to N-1 so requester 0 wins first.
module rr_arbiter
    import wr_req_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic                      block,
    output logic [N-1:0]              gnt,
    output logic [idx_width(N)-1:0]   gnt_idx
);

    localparam int IDX_W = idx_width(N);

    logic [IDX_W-1:0] last;
    logic             found;
    int               cand;

    // Scan from the requester just after the last grant, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        if (!block) begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(last) + k) % N;
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = IDX_W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IDX_W'(N - 1);
        end else if (|gnt) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/wr_req_arbiter.sv
// rtl/wr_req_arbiter.sv - shares the CCI write-request channel among CLIENTS requesters
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   c_req_en/addr/mdata/data    : per-client request, client i in slice i
//   c_req_gnt                   : combinational one-hot grant (accept on en&gnt)
//   c_rsp0/1_valid, _mdata      : routed write responses, ID stripped
//   c_idle                      : client has no outstanding writes
//   wr_req_*                    : CCI write request (mdata = {client ID, client mdata})
//   wr_req_almostfull           : CCI backpressure, blocks new grants
//   wr_rsp0/1_*                 : CCI write responses
//   err                         : sticky: bad response ID or counter underflow
module wr_req_arbiter
    import wr_req_arbiter_pkg::*;
#(
    parameter int ADDR_LMT    = ADDR_LMT_DEF,
    parameter int MDATA       = MDATA_DEF,
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
    parameter int CLIENTS     = CLIENTS_DEF,
    parameter int CID_W       = CID_W_DEF,
    parameter int MAX_OUT     = MAX_OUT_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CLIENTS-1:0]                 c_req_en,
    input  logic [CLIENTS*ADDR_LMT-1:0]        c_req_addr,
    input  logic [CLIENTS*(MDATA-CID_W)-1:0]   c_req_mdata,
    input  logic [CLIENTS*CACHE_WIDTH-1:0]     c_req_data,
    output logic [CLIENTS-1:0]                 c_req_gnt,
    output logic [CLIENTS-1:0]                 c_rsp0_valid,
    output logic [CLIENTS-1:0]                 c_rsp1_valid,
    output logic [MDATA-CID_W-1:0]             c_rsp0_mdata,
    output logic [MDATA-CID_W-1:0]             c_rsp1_mdata,
    output logic [CLIENTS-1:0]                 c_idle,
    output logic [ADDR_LMT-1:0]                wr_req_addr,
    output logic [MDATA-1:0]                   wr_req_mdata,
    output logic [CACHE_WIDTH-1:0]             wr_req_data,
    output logic                               wr_req_en,
    input  logic                               wr_req_almostfull,
    input  logic                               wr_rsp0_valid,
    input  logic [MDATA-1:0]                   wr_rsp0_mdata,
    input  logic                               wr_rsp1_valid,
    input  logic [MDATA-1:0]                   wr_rsp1_mdata,
    output logic                               err
);

    localparam int LOW_W = cid_lsb(MDATA, CID_W);
    localparam int CNT_W = cnt_width(MAX_OUT);
    localparam int IDX_W = idx_width(CLIENTS);

    logic [CNT_W-1:0]       out_cnt [CLIENTS];
    logic [CNT_W-1:0]       cnt_nxt [CLIENTS];
    logic [CLIENTS-1:0]     elig;
    logic [CLIENTS-1:0]     hit0;
    logic [CLIENTS-1:0]     hit1;
    logic [CLIENTS-1:0]     under;
    logic                   bad0;
    logic                   bad1;
    logic [CID_W-1:0]       id0;
    logic [CID_W-1:0]       id1;
    logic [IDX_W-1:0]       gnt_idx;
    logic [ADDR_LMT-1:0]    sel_addr;
    logic [MDATA-1:0]       sel_mdata;
    logic [CACHE_WIDTH-1:0] sel_data;
    int                     cnt_sum;

    // Eligibility uses the registered count only, so a response landing in
    // the same cycle does not unblock a full client until the next cycle.
    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            elig[i] = c_req_en[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N (CLIENTS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .block   (wr_req_almostfull | rst),
        .gnt     (c_req_gnt),
        .gnt_idx (gnt_idx)
    );

    // Payload of the granted client, tagged with its ID.
    always_comb begin
        sel_addr  = c_req_addr[int'(gnt_idx)*ADDR_LMT +: ADDR_LMT];
        sel_data  = c_req_data[int'(gnt_idx)*CACHE_WIDTH +: CACHE_WIDTH];
        sel_mdata = MDATA'(tag_mdata(64'(gnt_idx),
                                     64'(c_req_mdata[int'(gnt_idx)*LOW_W +: LOW_W]),
                                     LOW_W));
    end

    // Response decode: IDs beyond CLIENTS are dropped and flagged.
    always_comb begin
        id0  = CID_W'(mdata_cid(64'(wr_rsp0_mdata), LOW_W, CID_W));
        id1  = CID_W'(mdata_cid(64'(wr_rsp1_mdata), LOW_W, CID_W));
        bad0 = wr_rsp0_valid && (mdata_cid(64'(wr_rsp0_mdata), LOW_W, CID_W) >= 64'(CLIENTS));
        bad1 = wr_rsp1_valid && (mdata_cid(64'(wr_rsp1_mdata), LOW_W, CID_W) >= 64'(CLIENTS));
        for (int i = 0; i < CLIENTS; i++) begin
            hit0[i] = wr_rsp0_valid && !bad0 && (id0 == CID_W'(i));
            hit1[i] = wr_rsp1_valid && !bad1 && (id1 == CID_W'(i));
        end
    end

    // Net count change per client; a negative result clamps at zero.
    always_comb begin
        cnt_sum = 0;
        for (int i = 0; i < CLIENTS; i++) begin
            cnt_sum = int'(out_cnt[i]) + (c_req_gnt[i] ? 1 : 0)
                      - (hit0[i] ? 1 : 0) - (hit1[i] ? 1 : 0);
            under[i]   = (cnt_sum < 0);
            cnt_nxt[i] = (cnt_sum < 0) ? '0 : CNT_W'(cnt_sum);
        end
    end

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            c_idle[i] = (out_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLIENTS; i++) begin
                out_cnt[i] <= '0;
            end
            wr_req_en    <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_mdata <= '0;
            wr_req_data  <= '0;
            c_rsp0_valid <= '0;
            c_rsp1_valid <= '0;
            c_rsp0_mdata <= '0;
            c_rsp1_mdata <= '0;
            err          <= 1'b0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                out_cnt[i] <= cnt_nxt[i];
            end
            wr_req_en <= |c_req_gnt;
            if (|c_req_gnt) begin
                wr_req_addr  <= sel_addr;
                wr_req_mdata <= sel_mdata;
                wr_req_data  <= sel_data;
            end
            c_rsp0_valid <= hit0;
            c_rsp1_valid <= hit1;
            if (|hit0) begin
                c_rsp0_mdata <= wr_rsp0_mdata[LOW_W-1:0];
            end
            if (|hit1) begin
                c_rsp1_mdata <= wr_rsp1_mdata[LOW_W-1:0];
            end
            err <= err | bad0 | bad1 | (|under);
        end
    end

endmodule

// File: tb/tb_wr_req_arbiter.sv
// tb/tb_wr_req_arbiter.sv - self-checking bench for wr_req_arbiter
module tb_wr_req_arbiter;

    localparam int AW  = 20;
    localparam int MD  = 14;
    localparam int DW  = 512;
    localparam int N   = 3;
    localparam int CW  = 2;
    localparam int MO  = 2;
    localparam int LW  = MD - CW;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        c_req_en;
    logic [N*AW-1:0]     c_req_addr;
    logic [N*LW-1:0]     c_req_mdata;
    logic [N*DW-1:0]     c_req_data;
    logic [N-1:0]        c_req_gnt;
    logic [N-1:0]        c_rsp0_valid;
    logic [N-1:0]        c_rsp1_valid;
    logic [LW-1:0]       c_rsp0_mdata;
    logic [LW-1:0]       c_rsp1_mdata;
    logic [N-1:0]        c_idle;
    logic [AW-1:0]       wr_req_addr;
    logic [MD-1:0]       wr_req_mdata;
    logic [DW-1:0]       wr_req_data;
    logic                wr_req_en;
    logic                wr_req_almostfull = 1'b0;
    logic                wr_rsp0_valid = 1'b0;
    logic [MD-1:0]       wr_rsp0_mdata = '0;
    logic                wr_rsp1_valid = 1'b0;
    logic [MD-1:0]       wr_rsp1_mdata = '0;
    logic                err;

    // Client-side stimulus state.
    logic [N-1:0]  en = '0;
    logic [AW-1:0] a  [N];
    logic [LW-1:0] md [N];
    logic [DW-1:0] d  [N];
    int            md_next [N];
    bit            use_seq = 1'b0;

    // Reference model: spec-level state of the arbiter.
    int            cnt [N];
    int            last;
    logic [N-1:0]  prev_gnt;
    bit            m_err;
    bit            m_wr_en;
    logic [AW-1:0] m_addr;
    logic [MD-1:0] m_md;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_rv0, m_rv1;
    logic [LW-1:0] m_rm0, m_rm1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        c_req_en = en;
        for (int i = 0; i < N; i++) begin
            c_req_addr[i*AW +: AW]  = a[i];
            c_req_mdata[i*LW +: LW] = md[i];
            c_req_data[i*DW +: DW]  = d[i];
        end
    end

    wr_req_arbiter #(
        .ADDR_LMT    (AW),
        .MDATA       (MD),
        .CACHE_WIDTH (DW),
        .CLIENTS     (N),
        .CID_W       (CW),
        .MAX_OUT     (MO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .c_req_en          (c_req_en),
        .c_req_addr        (c_req_addr),
        .c_req_mdata       (c_req_mdata),
        .c_req_data        (c_req_data),
        .c_req_gnt         (c_req_gnt),
        .c_rsp0_valid      (c_rsp0_valid),
        .c_rsp1_valid      (c_rsp1_valid),
        .c_rsp0_mdata      (c_rsp0_mdata),
        .c_rsp1_mdata      (c_rsp1_mdata),
        .c_idle            (c_idle),
        .wr_req_addr       (wr_req_addr),
        .wr_req_mdata      (wr_req_mdata),
        .wr_req_data       (wr_req_data),
        .wr_req_en         (wr_req_en),
        .wr_req_almostfull (wr_req_almostfull),
        .wr_rsp0_valid     (wr_rsp0_valid),
        .wr_rsp0_mdata     (wr_rsp0_mdata),
        .wr_rsp1_valid     (wr_rsp1_valid),
        .wr_rsp1_mdata     (wr_rsp1_mdata),
        .err               (err)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        last     = N - 1;
        prev_gnt = '0;
        m_err    = 1'b0;
        m_wr_en  = 1'b0;
        m_addr   = '0;
        m_md     = '0;
        m_data   = '0;
        m_rv0    = '0;
        m_rv1    = '0;
        m_rm0    = '0;
        m_rm1    = '0;
    endtask

    task automatic new_payload(input int i);
        a[i] = AW'($urandom);
        for (int k = 0; k < DW / 32; k++) d[i][k*32 +: 32] = $urandom;
        md[i] = use_seq ? LW'(md_next[i]) : LW'($urandom);
    endtask

    // One clock of stimulus, checking and model update.
    // f_ch: 0 none, 1 force wr_rsp0 = f_md, 2 force wr_rsp1 = f_md.
    task automatic cycle(input logic [N-1:0] mask, input int p_req, input int p_af,
                         input int p_rsp, input bit allow_bad, input int f_ch,
                         input logic [MD-1:0] f_md);
        int           avail [N];
        int           q [$];
        int           gi;
        int           j;
        int           t;
        bit           rv [2];
        logic [MD-1:0] rm [2];
        logic [CW-1:0] id;
        logic [N-1:0] eg, ei, h0, h1;

        // Clients hold a request until it is granted.
        for (int i = 0; i < N; i++) begin
            if (!(en[i] && !prev_gnt[i])) begin
                en[i] = mask[i] && ($urandom_range(99) < p_req);
                new_payload(i);
                if (en[i] && use_seq) md_next[i]++;
            end
        end
        wr_req_almostfull = ($urandom_range(99) < p_af);

        for (int i = 0; i < N; i++) avail[i] = cnt[i];
        for (int ch = 0; ch < 2; ch++) begin
            rv[ch] = 1'b0;
            rm[ch] = '0;
            if (f_ch == ch + 1) begin
                rv[ch] = 1'b1;
                rm[ch] = f_md;
            end else if ($urandom_range(99) < p_rsp) begin
                if (allow_bad) begin
                    rv[ch] = 1'b1;
                    rm[ch] = MD'($urandom);
                end else begin
                    q.delete();
                    for (int i = 0; i < N; i++) if (avail[i] > 0) q.push_back(i);
                    if (q.size() > 0) begin
                        j      = q[$urandom_range(q.size() - 1)];
                        rv[ch] = 1'b1;
                        rm[ch] = {CW'(j), LW'($urandom)};
                    end
                end
            end
            if (rv[ch]) begin
                id = rm[ch][MD-1 -: CW];
                if (int'(id) < N && avail[id] > 0) avail[id]--;
            end
        end
        wr_rsp0_valid = rv[0];
        wr_rsp0_mdata = rm[0];
        wr_rsp1_valid = rv[1];
        wr_rsp1_mdata = rm[1];

        @(negedge clk);
        gi = -1;
        if (!wr_req_almostfull) begin
            for (int k = 1; k <= N; k++) begin
                j = (last + k) % N;
                if (gi < 0 && en[j] && cnt[j] < MO) gi = j;
            end
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        ei = '0;
        for (int i = 0; i < N; i++) ei[i] = (cnt[i] == 0);

        check_eq("gnt", c_req_gnt, eg);
        check_eq("wr_req_en", wr_req_en, m_wr_en);
        if (m_wr_en) begin
            check_eq("wr_req_addr", wr_req_addr, m_addr);
            check_eq("wr_req_mdata", wr_req_mdata, m_md);
            check_eq("wr_req_data", wr_req_data, m_data);
        end
        check_eq("rsp0_valid", c_rsp0_valid, m_rv0);
        check_eq("rsp1_valid", c_rsp1_valid, m_rv1);
        if (|m_rv0) check_eq("rsp0_mdata", c_rsp0_mdata, m_rm0);
        if (|m_rv1) check_eq("rsp1_mdata", c_rsp1_mdata, m_rm1);
        check_eq("idle", c_idle, ei);
        check_eq("err", err, m_err);

        h0 = '0;
        h1 = '0;
        if (rv[0]) begin
            id = rm[0][MD-1 -: CW];
            if (int'(id) >= N) m_err = 1'b1; else h0[id] = 1'b1;
        end
        if (rv[1]) begin
            id = rm[1][MD-1 -: CW];
            if (int'(id) >= N) m_err = 1'b1; else h1[id] = 1'b1;
        end
        m_rv0 = h0;
        m_rv1 = h1;
        if (|h0) m_rm0 = rm[0][LW-1:0];
        if (|h1) m_rm1 = rm[1][LW-1:0];
        m_wr_en = (gi >= 0);
        if (gi >= 0) begin
            m_addr = a[gi];
            m_md   = {CW'(gi), md[gi]};
            m_data = d[gi];
            last   = gi;
        end
        for (int i = 0; i < N; i++) begin
            t = cnt[i] + int'(eg[i]) - int'(h0[i]) - int'(h1[i]);
            if (t < 0) begin
                t     = 0;
                m_err = 1'b1;
            end
            cnt[i] = t;
        end
        prev_gnt = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) cycle('0, 0, 0, 100, 1'b0, 0, '0);
    endtask

    task automatic reset_check(input string tag);
        check_eq({tag, "_wr_en"}, wr_req_en, 1'b0);
        check_eq({tag, "_err"}, err, 1'b0);
        check_eq({tag, "_idle"}, c_idle, {N{1'b1}});
        check_eq({tag, "_gnt"}, c_req_gnt, '0);
        check_eq({tag, "_rsp0_v"}, c_rsp0_valid, '0);
        check_eq({tag, "_rsp1_v"}, c_rsp1_valid, '0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            md_next[i] = 0;
            new_payload(i);
        end
        model_reset();
        #1;
        reset_check("init");
        check_eq("init_addr", wr_req_addr, '0);
        check_eq("init_mdata", wr_req_mdata, '0);
        check_eq("init_data", wr_req_data, '0);
        check_eq("init_rsp0_md", c_rsp0_mdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Client 1 alone, sequential mdata 5,6,7.
        use_seq    = 1'b1;
        md_next[1] = 5;
        for (int c = 0; c < 3; c++) cycle(3'b010, 100, 0, 100, 1'b0, 0, '0);
        use_seq = 1'b0;
        drain(6);

        // Clients 0 and 1 continuously: alternating grants.
        for (int c = 0; c < 6; c++) cycle(3'b011, 100, 0, 100, 1'b0, 0, '0);
        // Backpressure window then release.
        for (int c = 0; c < 4; c++) cycle(3'b011, 100, 100, 100, 1'b0, 0, '0);
        for (int c = 0; c < 2; c++) cycle(3'b011, 100, 0, 100, 1'b0, 0, '0);
        drain(8);

        // Outstanding limit on client 0, then one response unblocks it.
        for (int c = 0; c < 4; c++) cycle(3'b001, 100, 0, 0, 1'b0, 0, '0);
        cycle(3'b001, 100, 0, 0, 1'b0, 1, 14'h0001);
        for (int c = 0; c < 3; c++) cycle(3'b001, 100, 0, 0, 1'b0, 0, '0);
        drain(8);

        // Random traffic with legal responses.
        for (int c = 0; c < 300; c++) cycle(3'b111, 60, 20, 50, 1'b0, 0, '0);
        drain(10);

        // Underflow on client 1 sets the sticky error.
        cycle('0, 0, 0, 0, 1'b0, 2, {2'd1, 12'h000});
        cycle('0, 0, 0, 0, 1'b0, 0, '0);
        // Random traffic including bad IDs and stray responses.
        for (int c = 0; c < 60; c++) cycle(3'b111, 60, 20, 60, 1'b1, 0, '0);

        // Asynchronous reset in the middle of a cycle.
        for (int c = 0; c < 4; c++) cycle(3'b111, 100, 0, 30, 1'b0, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        reset_check("arst");
        en                = '0;
        wr_req_almostfull = 1'b0;
        wr_rsp0_valid     = 1'b0;
        wr_rsp1_valid     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 200; c++) cycle(3'b111, 70, 15, 50, 1'b0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_req_arbiter.md
Name: wr_req_arbiter

Overview:
- Shares the single CCI write-request channel (wr_req_*) between CLIENTS independent requesters, e.g. the write buffer and a direct-write path from the compute pipeline.
- Round-robin arbitration with per-client outstanding-write limits. Tags each request's mdata with the client ID.
- Demultiplexes both write-response channels (wr_rsp0/wr_rsp1) back to the issuing client.
- Sits between the user datapath and the AFU write interface.

Parameters:
- ADDR_LMT, 20: write address width.
- MDATA, 14: mdata width on the CCI side.
- CACHE_WIDTH, 512: write data width.
- CLIENTS, 2: number of requesters (2..4).
- CID_W, 1: client-ID width; must satisfy 2**CID_W >= CLIENTS.
- MAX_OUT, 32: maximum outstanding writes per client.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- c_req_en  in  CLIENTS  per-client request valid.
- c_req_addr  in  CLIENTS*ADDR_LMT  per-client address; client i occupies slice i.
- c_req_mdata  in  CLIENTS*(MDATA-CID_W)  per-client mdata.
- c_req_data  in  CLIENTS*CACHE_WIDTH  per-client data.
- c_req_gnt  out  CLIENTS  combinational one-hot grant; request accepted on the edge where en&gnt.
- c_rsp0_valid  out  CLIENTS  routed wr_rsp0.
- c_rsp1_valid  out  CLIENTS  routed wr_rsp1.
- c_rsp0_mdata  out  MDATA-CID_W  wr_rsp0 mdata with the ID stripped; shared bus, qualified by c_rsp0_valid.
- c_rsp1_mdata  out  MDATA-CID_W  same for wr_rsp1.
- c_idle  out  CLIENTS  client has zero outstanding writes.
- wr_req_addr  out  ADDR_LMT  CCI write address.
- wr_req_mdata  out  MDATA  {client ID, client mdata}.
- wr_req_data  out  CACHE_WIDTH  CCI write data.
- wr_req_en  out  1  CCI write request valid.
- wr_req_almostfull  in  1  CCI backpressure.
- wr_rsp0_valid  in  1  write response 0 valid.
- wr_rsp0_mdata  in  MDATA  write response 0 mdata.
- wr_rsp1_valid  in  1  write response 1 valid.
- wr_rsp1_mdata  in  MDATA  write response 1 mdata.
- err  out  1  sticky error: bad client ID or counter underflow.

Behaviour:
- Reset (async, immediate):
  - wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data = 0.
  - All c_rsp* = 0; c_req_gnt = 0; err = 0.
  - Outstanding counters = 0, so c_idle = all ones.
  - Round-robin last-grant pointer = CLIENTS-1, so client 0 wins first.
- Eligibility: client i is eligible when c_req_en[i] = 1 and out_cnt[i] < MAX_OUT (registered count).
- Grant:
  - No grant while wr_req_almostfull = 1.
  - Otherwise, exactly one grant goes to the first eligible client after the last-grant pointer, in cyclic order.
  - The pointer updates only on a grant.
- Issue: on the granted edge, the payload is registered. Next cycle, wr_req_en = 1 with addr, data, and mdata = {i[CID_W-1:0], c_req_mdata slice i}.
  - Without a grant, wr_req_en = 0 next cycle; addr/data hold their last value.
  - Throughput is 1 request/cycle; latency from grant edge to wr_req_en is 1 cycle.
- Client handshake: the client holds en and payload stable until it sees gnt. gnt depends only on registered state, c_req_en and wr_req_almostfull; there is no combinational path from wr_rsp*.
- Response routing:
  - wr_rspN_valid with ID = mdata[MDATA-1 -: CID_W] raises c_rspN_valid[ID] one cycle later, with c_rspN_mdata = the low MDATA-CID_W bits.
  - Both channels may target the same client in the same cycle; both are forwarded.
- Counters: out_cnt[i] next = out_cnt[i] + grant[i] - rsp0_hit[i] - rsp1_hit[i].
  - Width is clog2(MAX_OUT+1).
  - A simultaneous grant and two responses gives a net -1.
  - A counter at MAX_OUT with a same-cycle response still blocks that cycle's grant (conservative).
- Boundary conditions:
  - Response ID >= CLIENTS: dropped (no c_rsp valid), err set.
  - Response to a client whose net count would go below 0: counter clamps at 0, err set.
  - err clears only on rst.
  - almostfull rising while a request is in the output register: that request is still issued (the CCI FIFO headroom covers it); no new grant is made.
  - Reset mid-operation: in-flight requests are abandoned and counters are cleared; late responses after reset cause underflow and set err.
- c_idle[i] = (out_cnt[i] == 0), registered.

Decomposition:
- Shared package holds constants for the client-ID field position (MDATA-1 -: CID_W), clog2 of MAX_OUT, and a mdata-tag/untag helper function.
- One sub-module, rr_arbiter (CLIENTS-wide request/grant, pointer register, async-reset). Counters, tagging and response demux stay in wr_req_arbiter.

Test Plan:
- Only client 1 requests 3 writes back-to-back, client mdata = 5,6,7 -> wr_req_en high for 3 cycles starting 1 cycle after the first grant; wr_req_mdata = 0x2005,0x2006,0x2007 (MDATA=14, CID_W=1); c_idle[1] = 0.
- Both clients hold requests continuously for 6 cycles -> grants alternate 0,1,0,1,0,1.
- wr_req_almostfull = 1 for 4 cycles with both requesting -> c_req_gnt = 0 and wr_req_en = 0 during that window; the grant resumes the cycle almostfull drops.
- MAX_OUT = 2, client 0 issues 2 writes with no responses -> third request not granted; wr_rsp0 with mdata 0x0001 -> c_rsp0_valid[0] pulses with mdata 1 next cycle, and the grant resumes the following cycle.
- wr_rsp0 and wr_rsp1 both target client 1 in the same cycle while client 1 is granted -> both c_rsp valids pulse; out_cnt[1] drops by net 1.
- wr_rsp1 with ID 1 while client 1's count = 0 -> err = 1 and the count stays 0; rst pulse -> err = 0, c_idle = all ones, wr_req_en = 0 immediately (asynchronously).
